exu_div_iter_ctl: RTL and testbench
===================================

Name: exu_div_iter_ctl

Overview:
Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the inverse-operation companion to the pipelined EXU multiplier and runs as a non-blocking side unit of the EXU. Decode launches one operation at a time. The block raises `finish` with the result and decode writes it back. It uses radix-2 restoring division on magnitudes, followed by a sign fix-up.

Parameters:
- `DATA_W`, 32, operand and result width (only 32 is supported).
- `CNT_W`, 6, iteration counter width.

Ports:
- `clk`  in  1  top-level clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `scan_mode`  in  1  scan mode, passed to clock headers.
- `clk_override`  in  1  forces internal clock enables on.
- `freeze`  in  1  pipeline freeze; holds all state.
- `flush`  in  1  kills the in-flight operation.
- `dp`  in  `div_pkt_t`  {valid, unsign, rem}.
- `a`  in  32  dividend (rs1).
- `b`  in  32  divisor (rs2).
- `busy`  out  1  an operation is in flight.
- `finish`  out  1  one-cycle pulse; `out` is valid in this cycle.
- `out`  out  32  quotient or remainder.

Behaviour:
- Reset (async, `rst_l`=0): state IDLE; `busy`=0, `finish`=0, `out`=0, counter=0.
- Accept: `dp.valid & ~busy & ~flush & ~freeze` in cycle N. The block latches `a`, `b`, `unsign`, `rem`. It also records the sign flags `a_neg = ~unsign & a[31]` and `b_neg = ~unsign & b[31]`, and stores the magnitudes.
- `dp.valid` while `busy` is ignored. Decode guarantees this never happens.
- States:
  - IDLE → RUN on accept.
  - RUN: 32 iterations, one quotient bit per cycle. Shift {rem,q} left, trial subtract the divisor magnitude, keep the result if it is non-negative. Counter counts 0..31. RUN → FIX when counter = 31.
  - FIX: apply signs. Quotient is negated if `a_neg ^ b_neg`. Remainder is negated if `a_neg`. Select quotient or remainder by `rem`. Register the result to `out`. FIX → DONE.
  - DONE: `finish`=1 for exactly one cycle. DONE → IDLE.
- Latency: accept in cycle N gives `finish` in cycle N+34.
- `busy`=1 from N+1 through N+34 inclusive. A new accept is legal in cycle N+35.
- `out` holds its value after `finish` until the next FIX.
- Divide by zero (`b`=0):
  - quotient = 0xFFFFFFFF, for both signed and unsigned.
  - remainder = `a`.
  - The sign fix-up is bypassed for this case.
- Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0. The sign fix-up naturally yields this; no special case is needed.
- Flush:
  - In RUN or FIX: next state is IDLE, `busy`=0 next cycle, no `finish`, `out` unchanged.
  - Coincident with `dp.valid`: the valid is dropped.
  - In DONE: no effect; `finish` still pulses.
- Freeze: all state, counter and outputs hold, and `finish` stays asserted if frozen in DONE. Flush takes priority over freeze.
- Clocking:
  - Data registers use an `rvclkhdr` gated by `(busy | dp.valid | clk_override) & ~freeze`.
  - Control state uses the free-running `clk` with enable `~freeze`.

Optional Feature:
Macro `RV_DIV_EARLY_EXIT_EN`.
- Defined: a shortcut detect runs in the accept cycle. Cases:
  - `b`=0.
  - |a| < |b| (quotient 0, remainder `a`).
  - |b| = 1 (quotient ±a, remainder 0).
  
  On a match, RUN is skipped and the FIX result is produced directly: state goes to DONE at N+1 and `finish` is asserted in cycle N+1. The normal 32-iteration path is otherwise unchanged.
- Undefined: every operation takes the full N+34 latency; results are identical.

Decomposition:
- `veer_types` gains `div_pkt_t` {valid, unsign, rem} and the state encoding enum `div_state_e` {IDLE, RUN, FIX, DONE}.
- One sub-module, `exu_div_cmp_ctl`: combinational magnitude and shortcut detect (|a|<|b|, b==0, |b|==1). It is instantiated only under `RV_DIV_EARLY_EXIT_EN`.

Test Plan:
- DIV, a=7, b=0xFFFFFFFE → `out`=0xFFFFFFFD at N+34; REM with the same operands → `out`=0x00000001.
- DIVU, a=100, b=7 → `out`=14; REMU with the same operands → `out`=2. `busy` is high N+1..N+34 and `finish` is a single-cycle pulse.
- DIV a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5; DIVU a=0x80000000, b=0 → 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Accept at N, flush at N+10 → no `finish`, `busy`=0 at N+11, `out` unchanged. A new DIVU 9/3 accepted at N+11 gives `out`=3 at N+45.
- DIVU a=3, b=10:
  - With `RV_DIV_EARLY_EXIT_EN` → `out`=0 with `finish` at N+1.
  - Without it → `out`=0 at N+34.
  - A 4-cycle freeze mid-RUN delays `finish` by exactly 4 cycles.

Source files
------------

// File: rtl/veer_types.sv
// veer_types: shared EXU types, including the iterative divider packet and state encoding.
package veer_types;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W = 6;
  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } div_pkt_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
  // Divide-by-zero keeps the all-ones quotient unsigned; the remainder fix-up still restores a.
  function automatic logic [DIV_DATA_W-1:0] div_fix(input logic [DIV_DATA_W-1:0] q, r,
                                                    input logic an, bn, bz, sel);
    return sel ? (an ? -r : r) : ((an ^ bn) & ~bz ? -q : q);
  endfunction
endpackage

// File: rtl/exu_div_cmp_ctl.sv
// exu_div_cmp_ctl: accept-cycle shortcut detect (b==0, |a|<|b|, |b|==1) with unsigned-domain results.
module exu_div_cmp_ctl
  import veer_types::*;
(
  input  logic [DIV_DATA_W-1:0] a_mag,
  input  logic [DIV_DATA_W-1:0] b_mag,
  output logic                  hit,
  output logic [DIV_DATA_W-1:0] q,
  output logic [DIV_DATA_W-1:0] r
);
  logic b_zero, b_one, a_lt;
  always_comb begin
    b_zero = b_mag == '0;
    b_one = b_mag == DIV_DATA_W'(1);
    a_lt = a_mag < b_mag;
    hit = b_zero | b_one | a_lt;
    q = b_zero ? '1 : b_one ? a_mag : '0;
    r = b_one ? '0 : a_mag;
  end
endmodule

// File: rtl/rvclkhdr.sv
// rvclkhdr: latch-based clock gate; scan_mode forces the gated clock on.
module rvclkhdr (
  input  logic en,
  input  logic clk,
  input  logic scan_mode,
  output logic l1clk
);
  logic en_ff;
  always_latch
    if (!clk) en_ff = en | scan_mode;
  assign l1clk = clk & en_ff;
endmodule

// File: rtl/exu_div_iter_ctl.sv
// exu_div_iter_ctl: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU).
// RV_DIV_EARLY_EXIT_EN: resolve b==0, |a|<|b| and |b|==1 in the accept cycle.
module exu_div_iter_ctl
  import veer_types::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scan_mode,
  input  logic              clk_override,
  input  logic              freeze,
  input  logic              flush,
  input  div_pkt_t          dp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              finish,
  output logic [DATA_W-1:0] out
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, a_neg, b_neg, sc_hit, l1clk, last;
  logic [DATA_W-1:0] a_mag, b_mag, sc_q, sc_r;
  logic [DATA_W:0] trial;
  logic a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d, sel_rem_q, sel_rem_d;
  logic [DATA_W-1:0] bm_q, bm_d, pr_q, pr_d, quo_q, quo_d, out_q, out_d;
  assign busy = state_q != IDLE;
  assign finish = state_q == DONE;
  assign out = out_q;
  assign accept = dp.valid & ~busy & ~flush & ~freeze;
  assign a_neg = ~dp.unsign & a[DATA_W-1];
  assign b_neg = ~dp.unsign & b[DATA_W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
`ifdef RV_DIV_EARLY_EXIT_EN
  exu_div_cmp_ctl u_cmp (
    .a_mag(a_mag),
    .b_mag(b_mag),
    .hit  (sc_hit),
    .q    (sc_q),
    .r    (sc_r)
  );
`else
  assign sc_hit = 1'b0;
  assign sc_q = '0;
  assign sc_r = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last = cnt_q == CNT_W'(DATA_W - 1);
    if (flush & (state_q == RUN | state_q == FIX)) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (!freeze) begin
      unique case (state_q)
        IDLE: state_d = accept ? (sc_hit ? DONE : RUN) : IDLE;
        RUN: begin
          state_d = last ? FIX : RUN;
          cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        FIX: state_d = DONE;
        DONE: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // A negative 33-bit trial difference means the shifted remainder is restored.
  always_comb begin
    trial = {pr_q, quo_q[DATA_W-1]} - {1'b0, bm_q};
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    b_zero_d = b_zero_q;
    sel_rem_d = sel_rem_q;
    bm_d = bm_q;
    pr_d = pr_q;
    quo_d = quo_q;
    out_d = out_q;
    if (accept) begin
      a_neg_d = a_neg;
      b_neg_d = b_neg;
      b_zero_d = b == '0;
      sel_rem_d = dp.rem;
      bm_d = b_mag;
      pr_d = '0;
      quo_d = a_mag;
      out_d = sc_hit ? div_fix(sc_q, sc_r, a_neg, b_neg, b == '0, dp.rem) : out_q;
    end else if (state_q == RUN) begin
      pr_d = trial[DATA_W] ? {pr_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    end else if (state_q == FIX & ~flush) begin
      out_d = div_fix(quo_q, pr_q, a_neg_q, b_neg_q, b_zero_q, sel_rem_q);
    end
  end
  rvclkhdr u_clkhdr (
    .en       ((busy | dp.valid | clk_override) & ~freeze),
    .clk      (clk),
    .scan_mode(scan_mode),
    .l1clk    (l1clk)
  );
  always_ff @(posedge l1clk or negedge rst_l)
    if (!rst_l) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      b_zero_q <= 1'b0;
      sel_rem_q <= 1'b0;
      bm_q <= '0;
      pr_q <= '0;
      quo_q <= '0;
      out_q <= '0;
    end else begin
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      b_zero_q <= b_zero_d;
      sel_rem_q <= sel_rem_d;
      bm_q <= bm_d;
      pr_q <= pr_d;
      quo_q <= quo_d;
      out_q <= out_d;
    end
endmodule

// File: tb/tb_exu_div_iter_ctl.sv
// tb_exu_div_iter_ctl: directed and random RV32M divide checks against an arithmetic reference.
module tb_exu_div_iter_ctl;
  import veer_types::*;
  logic clk = 1'b0, rst_l = 1'b1, scan_mode = 1'b0, clk_override = 1'b0, freeze = 1'b0, flush = 1'b0;
  div_pkt_t dp = '0;
  logic [31:0] a_i = '0, b_i = '0, out;
  logic busy, finish;
  int n_tot = 0, n_bad = 0;

  exu_div_iter_ctl dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .clk_override(clk_override),
    .freeze(freeze), .flush(flush), .dp(dp), .a(a_i), .b(b_i),
    .busy(busy), .finish(finish), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic u, input logic r, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return r ? x : 32'hFFFF_FFFF;
    if (u) return r ? x % y : x / y;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : x;
    return r ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic logic [31:0] mag(input logic u, input logic [31:0] x);
    return (!u && x[31]) ? -x : x;
  endfunction

  function automatic int base_lat(input logic u, input logic [31:0] x, input logic [31:0] y);
    int early_lat;
    logic sc;
    early_lat = 34;
`ifdef RV_DIV_EARLY_EXIT_EN
    early_lat = 1;
`endif
    sc = y == 0 || mag(u, x) < mag(u, y) || mag(u, y) == 1;
    return sc ? early_lat : 34;
  endfunction

  // Called just after a falling edge; returns at the falling edge after finish drops.
  task automatic run_op(input string tag, input logic u, input logic r, input logic [31:0] x,
                        input logic [31:0] y, input int f, input int l);
    logic [31:0] exp, got;
    int base, first, width;
    logic berr, done;
    exp = ref_div(u, r, x, y);
    base = base_lat(u, x, y);
    first = 0;
    width = 0;
    berr = 1'b0;
    done = 1'b0;
    got = '0;
    dp.valid = 1'b1;
    dp.unsign = u;
    dp.rem = r;
    a_i = x;
    b_i = y;
    @(negedge clk);
    dp.valid = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    for (int k = 1; k <= 100 && !done; k++) begin
      freeze = l > 0 && k >= f && k < f + l;
      if (finish) begin
        if (first == 0) begin
          first = k;
          got = out;
        end
        width++;
      end else if (first != 0) begin
        done = 1'b1;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, out, exp);
      end
      if (!busy && first == 0) berr = 1'b1;
      if (!done) @(negedge clk);
    end
    freeze = 1'b0;
    chk({tag, "_lat"}, 32'(first), 32'((l > 0 && f < base) ? base + l : base));
    chk({tag, "_pulse"}, 32'(width), 32'((l > 0 && f == base) ? l + 1 : 1));
    chk({tag, "_out"}, got, exp);
    chk({tag, "_busy"}, 32'(berr), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    logic saw;
    #2 rst_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_out", out, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);
    run_op("div_neg", 0, 0, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op("rem_neg", 0, 1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op("divu", 1, 0, 32'd100, 32'd7, 0, 0);
    run_op("remu", 1, 1, 32'd100, 32'd7, 0, 0);
    run_op("div_z", 0, 0, 32'd5, 32'd0, 0, 0);
    run_op("rem_z", 0, 1, 32'd5, 32'd0, 0, 0);
    run_op("divu_z", 1, 0, 32'h8000_0000, 32'd0, 0, 0);
    run_op("rem_negz", 0, 1, 32'hFFFF_FFF9, 32'd0, 0, 0);
    run_op("div_ovf", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("rem_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_small", 1, 0, 32'd3, 32'd10, 0, 0);
    run_op("frz_run", 1, 0, 32'd1000, 32'd7, 5, 4);
    run_op("frz_done", 1, 1, 32'd100, 32'd7, 34, 2);
    prev = out;
    saw = 1'b0;
    dp.valid = 1'b1;
    dp.unsign = 1'b1;
    dp.rem = 1'b0;
    a_i = 32'd1000;
    b_i = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      dp.valid = 1'b0;
      saw = saw | finish;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_fin", 32'(saw | finish), 32'd0);
    chk("flush_out", out, prev);
    run_op("after_flush", 1, 0, 32'd9, 32'd3, 0, 0);
    dp.valid = 1'b1;
    flush = 1'b1;
    a_i = 32'd3;
    b_i = 32'd10;
    @(negedge clk);
    dp.valid = 1'b0;
    flush = 1'b0;
    chk("vflush_busy", 32'(busy), 32'd0);
    chk("vflush_fin", 32'(finish), 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic u, r;
      int xs, ys, f, l, base;
      xs = $urandom_range(0, 3);
      ys = $urandom_range(0, 7);
      x = xs == 0 ? 32'h8000_0000 : xs == 1 ? 32'($urandom_range(0, 20)) : $urandom;
      y = ys == 0 ? 32'd0 : ys == 1 ? 32'($urandom_range(1, 20)) : ys == 2 ? 32'hFFFF_FFFF :
          ys == 3 ? 32'd1 : ys == 4 ? -32'($urandom_range(1, 20)) : $urandom;
      u = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      base = base_lat(u, x, y);
      f = 0;
      l = 0;
      if ($urandom_range(0, 3) == 0) begin
        l = $urandom_range(1, 3);
        f = base > 1 ? $urandom_range(1, base) : 1;
      end
      run_op("rnd", u, r, x, y, f, l);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
